// File: rtl/vga_timing_gen.sv
// vga_timing_gen
// Parametrised VGA raster timing generator. A clock divider produces a
// one-clk pixel strobe; horizontal and vertical counters step on that
// strobe. Sync and active flags are registered from the next-state counter
// values so they line up exactly with o_x/o_y.
module vga_timing_gen #(
   parameter int H_ACTIVE = 640,
   parameter int H_FP     = 16,
   parameter int H_SYNC   = 96,
   parameter int H_BP     = 48,
   parameter int V_ACTIVE = 480,
   parameter int V_FP     = 10,
   parameter int V_SYNC   = 2,
   parameter int V_BP     = 33,
   parameter bit HS_POL   = 1'b0,
   parameter bit VS_POL   = 1'b0,
   parameter int CLK_DIV  = 2,
   parameter int CW       = 10
) (
   input  logic          clk,
   input  logic          rst_n,
   input  logic          en,
   output logic          o_hs,
   output logic          o_vs,
   output logic [CW-1:0] o_x,
   output logic [CW-1:0] o_y,
   output logic          o_active,
   output logic          o_pix_en,
   output logic          o_line_start,
   output logic          o_frame_start
);

   localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
   localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
   localparam int DW      = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
   localparam int CW1     = CW + 1;

   localparam logic [DW-1:0] DIV_LAST = DW'(CLK_DIV - 1);
   localparam logic [CW-1:0] H_LAST   = CW'(H_TOTAL - 1);
   localparam logic [CW-1:0] V_LAST   = CW'(V_TOTAL - 1);

   // Region bounds are one bit wider than the counters so that a sync
   // region ending exactly at 2^CW still compares correctly.
   localparam logic [CW:0] HS_BEGIN = CW1'(H_ACTIVE + H_FP);
   localparam logic [CW:0] HS_END   = CW1'(H_ACTIVE + H_FP + H_SYNC);
   localparam logic [CW:0] VS_BEGIN = CW1'(V_ACTIVE + V_FP);
   localparam logic [CW:0] VS_END   = CW1'(V_ACTIVE + V_FP + V_SYNC);
   localparam logic [CW:0] H_VIS    = CW1'(H_ACTIVE);
   localparam logic [CW:0] V_VIS    = CW1'(V_ACTIVE);

   logic [DW-1:0] divCnt_q, divCnt_d;
   logic [CW-1:0] hCnt_q, hCnt_d;
   logic [CW-1:0] vCnt_q, vCnt_d;
   logic          hs_q, hs_d;
   logic          vs_q, vs_d;
   logic          active_q, active_d;
   logic          pixEn;
   logic [CW:0]   hWide, vWide;

   // Pixel strobe and next-state counters; the strobe is forced low while
   // reset is held so a CLK_DIV of 1 cannot leak a strobe during reset.
   always_comb begin
      pixEn    = rst_n & en & (divCnt_q == DIV_LAST);
      divCnt_d = divCnt_q;
      hCnt_d   = hCnt_q;
      vCnt_d   = vCnt_q;
      if (en) begin
         divCnt_d = (divCnt_q == DIV_LAST) ? '0 : divCnt_q + DW'(1);
      end
      if (pixEn) begin
         if (hCnt_q == H_LAST) begin
            hCnt_d = '0;
            vCnt_d = (vCnt_q == V_LAST) ? '0 : vCnt_q + CW'(1);
         end else begin
            hCnt_d = hCnt_q + CW'(1);
         end
      end
   end

   // Sync and active flags decoded from the next-state counters, so the
   // registered versions change on the same edge as o_x/o_y.
   always_comb begin
      hWide    = {1'b0, hCnt_d};
      vWide    = {1'b0, vCnt_d};
      hs_d     = ((hWide >= HS_BEGIN) && (hWide < HS_END)) ? HS_POL : ~HS_POL;
      vs_d     = ((vWide >= VS_BEGIN) && (vWide < VS_END)) ? VS_POL : ~VS_POL;
      active_d = (hWide < H_VIS) && (vWide < V_VIS);
   end

   // State registers; reset parks the raster at (0,0) with sync idle.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         divCnt_q <= '0;
         hCnt_q   <= '0;
         vCnt_q   <= '0;
         hs_q     <= ~HS_POL;
         vs_q     <= ~VS_POL;
         active_q <= 1'b1;
      end else begin
         divCnt_q <= divCnt_d;
         hCnt_q   <= hCnt_d;
         vCnt_q   <= vCnt_d;
         hs_q     <= hs_d;
         vs_q     <= vs_d;
         active_q <= active_d;
      end
   end

   assign o_x           = hCnt_q;
   assign o_y           = vCnt_q;
   assign o_hs          = hs_q;
   assign o_vs          = vs_q;
   assign o_active      = active_q;
   assign o_pix_en      = pixEn;
   assign o_line_start  = pixEn & (hCnt_q == '0);
   assign o_frame_start = pixEn & (hCnt_q == '0) & (vCnt_q == '0);

endmodule

// File: tb/tb_vga_timing_gen.sv
// tb_vga_timing_gen
// Three instances: default 640x480 timing (A), a mid-sized configuration
// small enough to run whole frames (B), and the tiny active-high config (C).
// Expected values come from a closed-form raster model driven by the count
// of enabled clock edges since reset release.
module tb_vga_timing_gen;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic       rstA_n, enA, aHs, aVs, aActive, aPix, aLine, aFrame;
   logic [9:0] aX, aY;
   logic       rstB_n, enB, bHs, bVs, bActive, bPix, bLine, bFrame;
   logic [5:0] bX, bY;
   logic       rstC_n, enC, cHs, cVs, cActive, cPix, cLine, cFrame;
   logic [2:0] cX, cY;

   int checks = 0;
   int errors = 0;
   int eA, eB, eC;

   logic [15:0] expX, expY;
   logic        expHs, expVs, expActive, expPix, expLine, expFrame;

   vga_timing_gen dutA (
      .clk(clk), .rst_n(rstA_n), .en(enA), .o_hs(aHs), .o_vs(aVs), .o_x(aX), .o_y(aY),
      .o_active(aActive), .o_pix_en(aPix), .o_line_start(aLine), .o_frame_start(aFrame));

   vga_timing_gen #(
      .H_ACTIVE(40), .H_FP(4), .H_SYNC(8), .H_BP(4),
      .V_ACTIVE(30), .V_FP(3), .V_SYNC(2), .V_BP(5),
      .HS_POL(1'b0), .VS_POL(1'b0), .CLK_DIV(3), .CW(6)
   ) dutB (
      .clk(clk), .rst_n(rstB_n), .en(enB), .o_hs(bHs), .o_vs(bVs), .o_x(bX), .o_y(bY),
      .o_active(bActive), .o_pix_en(bPix), .o_line_start(bLine), .o_frame_start(bFrame));

   vga_timing_gen #(
      .H_ACTIVE(4), .H_FP(1), .H_SYNC(2), .H_BP(1),
      .V_ACTIVE(3), .V_FP(1), .V_SYNC(1), .V_BP(1),
      .HS_POL(1'b1), .VS_POL(1'b1), .CLK_DIV(1), .CW(3)
   ) dutC (
      .clk(clk), .rst_n(rstC_n), .en(enC), .o_hs(cHs), .o_vs(cVs), .o_x(cX), .o_y(cY),
      .o_active(cActive), .o_pix_en(cPix), .o_line_start(cLine), .o_frame_start(cFrame));

   // Raster model: e enabled edges since release, pixel index e/div.
   task automatic model(input int e, input bit enNow, input int hAct, input int hFp,
                        input int hSync, input int hBp, input int vAct, input int vFp,
                        input int vSync, input int vBp, input bit hsPol, input bit vsPol,
                        input int div);
      int hTot, vTot, p, x, y;
      hTot      = hAct + hFp + hSync + hBp;
      vTot      = vAct + vFp + vSync + vBp;
      p         = e / div;
      x         = p % hTot;
      y         = (p / hTot) % vTot;
      expX      = 16'(x);
      expY      = 16'(y);
      expPix    = enNow && ((e % div) == div - 1);
      expLine   = expPix && (x == 0);
      expFrame  = expLine && (y == 0);
      expHs     = (x >= hAct + hFp && x < hAct + hFp + hSync) ? hsPol : !hsPol;
      expVs     = (y >= vAct + vFp && y < vAct + vFp + vSync) ? vsPol : !vsPol;
      expActive = (x < hAct) && (y < vAct);
   endtask

   task automatic modelA();
      model(eA, enA, 640, 16, 96, 48, 480, 10, 2, 33, 1'b0, 1'b0, 2);
   endtask

   task automatic modelB();
      model(eB, enB, 40, 4, 8, 4, 30, 3, 2, 5, 1'b0, 1'b0, 3);
   endtask

   task automatic modelC();
      model(eC, enC, 4, 1, 2, 1, 3, 1, 1, 1, 1'b1, 1'b1, 1);
   endtask

   // Advance one clock, counting the edge only when run enable was high.
   task automatic tickA();
      @(posedge clk); if (enA) eA++; @(negedge clk);
   endtask

   task automatic tickB();
      @(posedge clk); if (enB) eB++; @(negedge clk);
   endtask

   task automatic tickC();
      @(posedge clk); if (enC) eC++; @(negedge clk);
   endtask

   task automatic test_reset();
      int firstEdge;
      rstA_n = 1'b0; enA = 1'b1;
      repeat (3) @(negedge clk);
      checks++; if (aX !== 10'd0) begin errors++; $display("[TB] FAIL reset.x got %0d exp 0", aX); end
      checks++; if (aY !== 10'd0) begin errors++; $display("[TB] FAIL reset.y got %0d exp 0", aY); end
      checks++; if (aActive !== 1'b1) begin errors++; $display("[TB] FAIL reset.active got %b exp 1", aActive); end
      checks++; if (aHs !== 1'b1) begin errors++; $display("[TB] FAIL reset.hs got %b exp 1", aHs); end
      checks++; if (aVs !== 1'b1) begin errors++; $display("[TB] FAIL reset.vs got %b exp 1", aVs); end
      checks++; if (aPix !== 1'b0) begin errors++; $display("[TB] FAIL reset.pix got %b exp 0", aPix); end
      checks++; if (aLine !== 1'b0) begin errors++; $display("[TB] FAIL reset.line got %b exp 0", aLine); end
      checks++; if (aFrame !== 1'b0) begin errors++; $display("[TB] FAIL reset.frame got %b exp 0", aFrame); end
      rstA_n = 1'b1; eA = 0;
      #1;
      checks++; if (aFrame !== 1'b0) begin errors++; $display("[TB] FAIL reset.frameAtRelease got %b exp 0", aFrame); end
      firstEdge = -1;
      for (int c = 1; c <= 4; c++) begin
         tickA();
         if (aFrame === 1'b1 && firstEdge < 0) firstEdge = c + 1;
      end
      checks++; if (firstEdge != 2) begin errors++; $display("[TB] FAIL reset.firstFrameStartEdge got %0d exp 2", firstEdge); end
   endtask

   task automatic test_hline();
      int hsLow, wraps, falls;
      logic [9:0] prevX, prevY;
      logic prevActive;
      hsLow = 0; wraps = 0; falls = 0;
      prevX = aX; prevY = aY; prevActive = aActive;
      for (int i = 0; i < 1640; i++) begin
         tickA(); modelA();
         checks++; if (aX !== expX[9:0]) begin errors++; $display("[TB] FAIL hline.x e=%0d got %0d exp %0d", eA, aX, expX[9:0]); end
         checks++; if (aY !== expY[9:0]) begin errors++; $display("[TB] FAIL hline.y e=%0d got %0d exp %0d", eA, aY, expY[9:0]); end
         checks++; if (aHs !== expHs) begin errors++; $display("[TB] FAIL hline.hs e=%0d got %b exp %b", eA, aHs, expHs); end
         checks++; if (aVs !== expVs) begin errors++; $display("[TB] FAIL hline.vs e=%0d got %b exp %b", eA, aVs, expVs); end
         checks++; if (aActive !== expActive) begin errors++; $display("[TB] FAIL hline.active e=%0d got %b exp %b", eA, aActive, expActive); end
         checks++; if (aPix !== expPix) begin errors++; $display("[TB] FAIL hline.pix e=%0d got %b exp %b", eA, aPix, expPix); end
         checks++; if (aLine !== expLine) begin errors++; $display("[TB] FAIL hline.line e=%0d got %b exp %b", eA, aLine, expLine); end
         checks++; if (aFrame !== expFrame) begin errors++; $display("[TB] FAIL hline.frame e=%0d got %b exp %b", eA, aFrame, expFrame); end
         if (expY == 16'd0 && aHs === 1'b0) hsLow++;
         if (prevX == 10'd639 && aX == 10'd640) begin
            falls++;
            checks++; if (!(prevActive === 1'b1 && aActive === 1'b0)) begin errors++; $display("[TB] FAIL hline.activeFall got %b->%b exp 1->0", prevActive, aActive); end
         end
         if (prevX == 10'd799 && aX == 10'd0) begin
            wraps++;
            checks++; if (aY !== prevY + 10'd1) begin errors++; $display("[TB] FAIL hline.wrapY got %0d exp %0d", aY, prevY + 10'd1); end
         end
         prevX = aX; prevY = aY; prevActive = aActive;
      end
      checks++; if (hsLow != 192) begin errors++; $display("[TB] FAIL hline.hsLowClks got %0d exp 192", hsLow); end
      checks++; if (wraps != 1) begin errors++; $display("[TB] FAIL hline.wrapCount got %0d exp 1", wraps); end
      checks++; if (falls != 1) begin errors++; $display("[TB] FAIL hline.activeFallCount got %0d exp 1", falls); end
   endtask

   task automatic test_en_gating();
      int guard;
      guard = 0;
      while ((eA % 2) != 1 && guard < 4) begin tickA(); guard++; end
      enA = 1'b0;
      #1;
      checks++; if (aPix !== 1'b0) begin errors++; $display("[TB] FAIL gate.pixDrop got %b exp 0", aPix); end
      for (int i = 0; i < 97; i++) begin
         if (i == 37) begin
            enA = 1'b1;
            #1;
            checks++; if (aPix !== 1'b1) begin errors++; $display("[TB] FAIL gate.pixResume got %b exp 1", aPix); end
         end
         tickA(); modelA();
         checks++; if (aX !== expX[9:0]) begin errors++; $display("[TB] FAIL gate.x e=%0d got %0d exp %0d", eA, aX, expX[9:0]); end
         checks++; if (aY !== expY[9:0]) begin errors++; $display("[TB] FAIL gate.y e=%0d got %0d exp %0d", eA, aY, expY[9:0]); end
         checks++; if (aHs !== expHs) begin errors++; $display("[TB] FAIL gate.hs e=%0d got %b exp %b", eA, aHs, expHs); end
         checks++; if (aVs !== expVs) begin errors++; $display("[TB] FAIL gate.vs e=%0d got %b exp %b", eA, aVs, expVs); end
         checks++; if (aActive !== expActive) begin errors++; $display("[TB] FAIL gate.active e=%0d got %b exp %b", eA, aActive, expActive); end
         checks++; if (aPix !== expPix) begin errors++; $display("[TB] FAIL gate.pix e=%0d got %b exp %b", eA, aPix, expPix); end
         checks++; if (aLine !== expLine) begin errors++; $display("[TB] FAIL gate.line e=%0d got %b exp %b", eA, aLine, expLine); end
         checks++; if (aFrame !== expFrame) begin errors++; $display("[TB] FAIL gate.frame e=%0d got %b exp %b", eA, aFrame, expFrame); end
      end
   endtask

   task automatic test_full_frame();
      int vsLow, fsCount, fs1, fs2, lineCnt;
      vsLow = 0; fsCount = 0; fs1 = 0; fs2 = 0; lineCnt = 0;
      rstB_n = 1'b0; enB = 1'b1;
      repeat (2) @(negedge clk);
      rstB_n = 1'b1; eB = 0;
      for (int i = 0; i < 13540; i++) begin
         tickB(); modelB();
         checks++; if (bX !== expX[5:0]) begin errors++; $display("[TB] FAIL frame.x e=%0d got %0d exp %0d", eB, bX, expX[5:0]); end
         checks++; if (bY !== expY[5:0]) begin errors++; $display("[TB] FAIL frame.y e=%0d got %0d exp %0d", eB, bY, expY[5:0]); end
         checks++; if (bHs !== expHs) begin errors++; $display("[TB] FAIL frame.hs e=%0d got %b exp %b", eB, bHs, expHs); end
         checks++; if (bVs !== expVs) begin errors++; $display("[TB] FAIL frame.vs e=%0d got %b exp %b", eB, bVs, expVs); end
         checks++; if (bActive !== expActive) begin errors++; $display("[TB] FAIL frame.active e=%0d got %b exp %b", eB, bActive, expActive); end
         checks++; if (bPix !== expPix) begin errors++; $display("[TB] FAIL frame.pix e=%0d got %b exp %b", eB, bPix, expPix); end
         checks++; if (bLine !== expLine) begin errors++; $display("[TB] FAIL frame.line e=%0d got %b exp %b", eB, bLine, expLine); end
         checks++; if (bFrame !== expFrame) begin errors++; $display("[TB] FAIL frame.frame e=%0d got %b exp %b", eB, bFrame, expFrame); end
         if (eB < 6720 && bVs === 1'b0) vsLow++;
         if (bFrame === 1'b1) begin
            fsCount++;
            if (fsCount == 1) fs1 = eB;
            if (fsCount == 2) fs2 = eB;
         end
         if (bLine === 1'b1 && fsCount == 1) lineCnt++;
      end
      checks++; if (vsLow != 336) begin errors++; $display("[TB] FAIL frame.vsLowClks got %0d exp 336", vsLow); end
      checks++; if (fsCount < 2 || fs2 - fs1 != 6720) begin errors++; $display("[TB] FAIL frame.period got %0d exp 6720", fs2 - fs1); end
      checks++; if (lineCnt != 40) begin errors++; $display("[TB] FAIL frame.linesPerFrame got %0d exp 40", lineCnt); end
   endtask

   task automatic test_reset_mid();
      int guard;
      guard = 0;
      modelB();
      while (!(expX == 16'd30 && expY == 16'd20) && guard < 7000) begin
         tickB(); modelB(); guard++;
      end
      checks++; if (bX !== 6'd30 || bY !== 6'd20) begin errors++; $display("[TB] FAIL mid.position got (%0d,%0d) exp (30,20)", bX, bY); end
      #2 rstB_n = 1'b0;
      #1;
      checks++; if (bX !== 6'd0) begin errors++; $display("[TB] FAIL mid.x got %0d exp 0", bX); end
      checks++; if (bY !== 6'd0) begin errors++; $display("[TB] FAIL mid.y got %0d exp 0", bY); end
      checks++; if (bActive !== 1'b1) begin errors++; $display("[TB] FAIL mid.active got %b exp 1", bActive); end
      checks++; if (bHs !== 1'b1) begin errors++; $display("[TB] FAIL mid.hs got %b exp 1", bHs); end
      checks++; if (bVs !== 1'b1) begin errors++; $display("[TB] FAIL mid.vs got %b exp 1", bVs); end
      checks++; if (bPix !== 1'b0 || bLine !== 1'b0 || bFrame !== 1'b0) begin errors++; $display("[TB] FAIL mid.strobes got %b%b%b exp 000", bPix, bLine, bFrame); end
      @(negedge clk);
      rstB_n = 1'b1; eB = 0;
      for (int i = 0; i < 200; i++) begin
         tickB(); modelB();
         checks++; if (bX !== expX[5:0]) begin errors++; $display("[TB] FAIL mid.restartX e=%0d got %0d exp %0d", eB, bX, expX[5:0]); end
         checks++; if (bY !== expY[5:0]) begin errors++; $display("[TB] FAIL mid.restartY e=%0d got %0d exp %0d", eB, bY, expY[5:0]); end
         checks++; if (bHs !== expHs) begin errors++; $display("[TB] FAIL mid.restartHs e=%0d got %b exp %b", eB, bHs, expHs); end
         checks++; if (bActive !== expActive) begin errors++; $display("[TB] FAIL mid.restartActive e=%0d got %b exp %b", eB, bActive, expActive); end
         checks++; if (bPix !== expPix) begin errors++; $display("[TB] FAIL mid.restartPix e=%0d got %b exp %b", eB, bPix, expPix); end
         checks++; if (bFrame !== expFrame) begin errors++; $display("[TB] FAIL mid.restartFrame e=%0d got %b exp %b", eB, bFrame, expFrame); end
      end
   endtask

   task automatic test_small_config();
      int hsHigh, vsHigh, lastFs, fsSeen;
      hsHigh = 0; vsHigh = 0; lastFs = 0; fsSeen = 0;
      rstC_n = 1'b0; enC = 1'b1;
      repeat (2) @(negedge clk);
      checks++; if (cPix !== 1'b0) begin errors++; $display("[TB] FAIL small.resetPix got %b exp 0", cPix); end
      checks++; if (cHs !== 1'b0 || cVs !== 1'b0) begin errors++; $display("[TB] FAIL small.resetSync got %b%b exp 00", cHs, cVs); end
      checks++; if (cActive !== 1'b1) begin errors++; $display("[TB] FAIL small.resetActive got %b exp 1", cActive); end
      rstC_n = 1'b1; eC = 0;
      #1;
      checks++; if (cPix !== 1'b1 || cFrame !== 1'b1) begin errors++; $display("[TB] FAIL small.firstStrobe got %b%b exp 11", cPix, cFrame); end
      for (int i = 0; i < 100; i++) begin
         tickC(); modelC();
         checks++; if (cX !== expX[2:0]) begin errors++; $display("[TB] FAIL small.x e=%0d got %0d exp %0d", eC, cX, expX[2:0]); end
         checks++; if (cY !== expY[2:0]) begin errors++; $display("[TB] FAIL small.y e=%0d got %0d exp %0d", eC, cY, expY[2:0]); end
         checks++; if (cHs !== expHs) begin errors++; $display("[TB] FAIL small.hs e=%0d got %b exp %b", eC, cHs, expHs); end
         checks++; if (cVs !== expVs) begin errors++; $display("[TB] FAIL small.vs e=%0d got %b exp %b", eC, cVs, expVs); end
         checks++; if (cActive !== expActive) begin errors++; $display("[TB] FAIL small.active e=%0d got %b exp %b", eC, cActive, expActive); end
         checks++; if (cPix !== 1'b1) begin errors++; $display("[TB] FAIL small.pix e=%0d got %b exp 1", eC, cPix); end
         checks++; if (cLine !== expLine) begin errors++; $display("[TB] FAIL small.line e=%0d got %b exp %b", eC, cLine, expLine); end
         checks++; if (cFrame !== expFrame) begin errors++; $display("[TB] FAIL small.frame e=%0d got %b exp %b", eC, cFrame, expFrame); end
         if (eC < 48 && cHs === 1'b1) hsHigh++;
         if (eC < 48 && cVs === 1'b1) vsHigh++;
         if (cFrame === 1'b1) begin
            fsSeen++;
            checks++; if (eC - lastFs != 48) begin errors++; $display("[TB] FAIL small.period got %0d exp 48", eC - lastFs); end
            lastFs = eC;
         end
      end
      checks++; if (hsHigh != 12) begin errors++; $display("[TB] FAIL small.hsHighClks got %0d exp 12", hsHigh); end
      checks++; if (vsHigh != 8) begin errors++; $display("[TB] FAIL small.vsHighClks got %0d exp 8", vsHigh); end
      checks++; if (fsSeen != 2) begin errors++; $display("[TB] FAIL small.frameCount got %0d exp 2", fsSeen); end
   endtask

   // Run every scenario in order, then report totals.
   initial begin
      rstA_n = 1'b0; enA = 1'b0;
      rstB_n = 1'b0; enB = 1'b0;
      rstC_n = 1'b0; enC = 1'b0;
      eA = 0; eB = 0; eC = 0;
      $display("[TB] starting vga_timing_gen bench");
      test_reset();
      test_hline();
      test_en_gating();
      test_full_frame();
      test_reset_mid();
      test_small_config();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
